// File: rtl/proc_mult_share_sched.sv
// rtl/proc_mult_share_sched.sv - shared 3-product multiplier scheduler; PROC_MULT_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration
module proc_mult_share_sched #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int MUL_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_src1,
    input  logic [NUM_REQ*32-1:0] req_src2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 busy,
    output logic [31:0]          mc_src1,
    output logic [31:0]          mc_src2,
    output logic                 mc_en,
    input  logic [31:0]          mc_p1,
    input  logic [31:0]          mc_p2,
    input  logic [31:0]          mc_p3
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COMBINE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ID_W-1:0]    id_q;
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [31:0]        sel_src1;
    logic [31:0]        sel_src2;
    logic               grant_fire;

`ifdef PROC_MULT_SCHED_FIXED_PRIO_EN
    // Fixed priority: scanning from the top down leaves the lowest set index as winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[IDX_W'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q;
    int               scan_idx;

    // Round-robin: first valid requester at or after the pointer, wrapping at NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[IDX_W'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(scan_idx);
            end
        end
    end

    // Pointer moves to the slot after the winner, only when a grant is actually made
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else if (grant_fire) begin
            rr_ptr_q <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // Operand mux for the winning requester
    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == grant_idx) begin
                sel_src1 = req_src1[k*32 +: 32];
                sel_src2 = req_src2[k*32 +: 32];
            end
        end
    end

    assign grant_fire = (state_q == IDLE) && grant_found;

    // Next-state and handshake/enable outputs; grant is gated off while reset is asserted
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        mc_en     = 1'b0;
        rsp_valid = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (grant_found && reset_n) begin
                    req_ready = NUM_REQ'(1) << grant_idx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                mc_en = 1'b1;
                if (cnt_q == '0) begin
                    state_d = COMBINE;
                end
            end
            COMBINE: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand latch (doubles as the held cell operands), enable counter and result fold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            id_q     <= '0;
            mc_src1  <= '0;
            mc_src2  <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        mc_src1 <= sel_src1;
                        mc_src2 <= sel_src2;
                        id_q    <= ID_W'(grant_idx);
                        cnt_q   <= CNT_W'(MUL_LATENCY - 1);
                    end
                end
                ISSUE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                COMBINE: begin
                    rsp_data <= mc_p1 + ((mc_p2 + mc_p3) << 16);
                    rsp_id   <= id_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_mult_share_sched.sv
// tb/tb_proc_mult_share_sched.sv - scoreboard bench for proc_mult_share_sched (latency 1 and latency 3 instances)
`timescale 1ns/1ps
module tb_proc_mult_share_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [3:0]   a_req_valid, a_req_ready;
    logic [127:0] a_src1, a_src2;
    logic         a_rsp_valid, a_rsp_ready;
    logic [1:0]   a_rsp_id;
    logic [31:0]  a_rsp_data;
    logic         a_busy, a_mc_en;
    logic [31:0]  a_mc_src1, a_mc_src2, a_p1, a_p2, a_p3;

    logic [3:0]   b_req_valid, b_req_ready;
    logic [127:0] b_src1, b_src2;
    logic         b_rsp_valid, b_rsp_ready;
    logic [1:0]   b_rsp_id;
    logic [31:0]  b_rsp_data;
    logic         b_busy, b_mc_en;
    logic [31:0]  b_mc_src1, b_mc_src2, b_p1, b_p2, b_p3;

    proc_mult_share_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LATENCY(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_src1(a_src1), .req_src2(a_src2),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_id(a_rsp_id), .rsp_data(a_rsp_data), .busy(a_busy),
        .mc_src1(a_mc_src1), .mc_src2(a_mc_src2), .mc_en(a_mc_en),
        .mc_p1(a_p1), .mc_p2(a_p2), .mc_p3(a_p3)
    );

    proc_mult_share_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LATENCY(3)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_src1(b_src1), .req_src2(b_src2),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .busy(b_busy),
        .mc_src1(b_mc_src1), .mc_src2(b_mc_src2), .mc_en(b_mc_en),
        .mc_p1(b_p1), .mc_p2(b_p2), .mc_p3(b_p3)
    );

    function automatic logic [31:0] pp(input logic [15:0] x, input logic [15:0] y);
        return {16'h0, x} * {16'h0, y};
    endfunction

    // Single-stage multiplier cell for the latency-1 instance
    always_ff @(posedge clk) begin
        if (a_mc_en) begin
            a_p1 <= pp(a_mc_src1[15:0],  a_mc_src2[15:0]);
            a_p2 <= pp(a_mc_src1[15:0],  a_mc_src2[31:16]);
            a_p3 <= pp(a_mc_src1[31:16], a_mc_src2[15:0]);
        end
    end

    logic [31:0] b_q1 [0:2];
    logic [31:0] b_q2 [0:2];
    logic [31:0] b_q3 [0:2];

    // Three-stage enabled pipeline cell for the latency-3 instance
    always_ff @(posedge clk) begin
        if (b_mc_en) begin
            b_q1[0] <= pp(b_mc_src1[15:0],  b_mc_src2[15:0]);
            b_q2[0] <= pp(b_mc_src1[15:0],  b_mc_src2[31:16]);
            b_q3[0] <= pp(b_mc_src1[31:16], b_mc_src2[15:0]);
            for (int s = 1; s < 3; s++) begin
                b_q1[s] <= b_q1[s-1];
                b_q2[s] <= b_q2[s-1];
                b_q3[s] <= b_q3[s-1];
            end
        end
    end
    assign b_p1 = b_q1[2];
    assign b_p2 = b_q2[2];
    assign b_p3 = b_q3[2];

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors    = 0;
    int   checks    = 0;
    int   model_ptr = 0;

    function automatic int model_grant(input logic [3:0] v, input int ptr);
        int idx;
`ifdef PROC_MULT_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (ptr + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic run_op(input logic [3:0] mask, input logic [127:0] s1, input logic [127:0] s2,
                          input int exp_id, input logic [31:0] exp_data, input string name);
        int   cyc;
        bit   ok;
        exp_t e;
        a_rsp_ready = 1'b1;
        a_src1      = s1;
        a_src2      = s2;
        a_req_valid = mask;
        sb.push_back('{id: 2'(exp_id), data: exp_data});
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
            ok = (a_req_ready != 4'b0);
        end
        checks++;
        if (a_req_ready !== 4'(1 << exp_id)) begin
            errors++;
            $display("FAIL %s grant: req_ready=%b expected %b", name, a_req_ready, 4'(1 << exp_id));
        end
        model_ptr = (exp_id + 1) % NUM_REQ;
        @(posedge clk);
        #1;
        a_req_valid = 4'b0;
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
            ok = a_rsp_valid;
        end
        e = sb.pop_front();
        checks++;
        if (!ok || cyc != 3) begin
            errors++;
            $display("FAIL %s latency: rsp_valid after %0d cycles (seen=%0d) expected 3", name, cyc, ok);
        end
        checks++;
        if (a_rsp_data !== e.data) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, a_rsp_data, e.data);
        end
        checks++;
        if (a_rsp_id !== e.id) begin
            errors++;
            $display("FAIL %s id: got %0d expected %0d", name, a_rsp_id, e.id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_req_valid = '0; a_src1 = '0; a_src2 = '0; a_rsp_ready = 1'b0;
        b_req_valid = '0; b_src1 = '0; b_src2 = '0; b_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_req_ready, a_rsp_valid, a_rsp_id, a_rsp_data, a_busy, a_mc_en, a_mc_src1, a_mc_src2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b vld=%b id=%0d data=%h busy=%b en=%b s1=%h s2=%h expected all 0",
                     a_req_ready, a_rsp_valid, a_rsp_id, a_rsp_data, a_busy, a_mc_en, a_mc_src1, a_mc_src2);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy a=%b b=%b expected 0", a_busy, b_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [127:0] v1, v2;
        v1 = '0; v2 = '0;
        v1[31:0] = 32'h00012345;
        v2[31:0] = 32'h00000010;
        run_op(4'b0001, v1, v2, 0, 32'h00123450, "basic");
        @(negedge clk);
        checks++;
        if (a_rsp_valid !== 1'b0 || a_busy !== 1'b0 || a_mc_src1 !== 32'h00012345 || a_mc_src2 !== 32'h00000010) begin
            errors++;
            $display("FAIL basic_after: vld=%b busy=%b mc_src1=%h mc_src2=%h expected 0 0 00012345 00000010",
                     a_rsp_valid, a_busy, a_mc_src1, a_mc_src2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        logic [127:0] v1, v2;
        v1 = '0; v2 = '0;
        v1[95:64] = 32'hFFFFFFFF;
        v2[95:64] = 32'hFFFFFFFF;
        run_op(4'b0100, v1, v2, 2, 32'h00000001, "wrap_ones");
        v1[95:64] = 32'h00010000;
        v2[95:64] = 32'h00010000;
        run_op(4'b0100, v1, v2, 2, 32'h00000000, "wrap_hi");
    endtask

    task automatic test_backpressure();
        int   cyc;
        bit   ok;
        exp_t e;
        a_rsp_ready = 1'b0;
        a_src1[127:96] = 32'hDEADBEEF;
        a_src2[127:96] = 32'h00000003;
        a_req_valid = 4'b1000;
        sb.push_back('{id: 2'd3, data: 32'hDEADBEEF * 32'd3});
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
            ok = (a_req_ready != 4'b0);
        end
        checks++;
        if (a_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_grant: req_ready=%b expected 1000", a_req_ready);
        end
        @(posedge clk);
        #1;
        a_src1[63:32] = 32'h00000007;
        a_src2[63:32] = 32'h00000009;
        a_req_valid = 4'b0010;
        sb.push_back('{id: 2'd1, data: 32'd63});
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
            ok = a_rsp_valid;
        end
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (a_rsp_valid !== 1'b1 || a_rsp_data !== e.data || a_rsp_id !== e.id || a_req_ready !== 4'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b data=%h id=%0d ready=%b expected 1 %h %0d 0000",
                         c, a_rsp_valid, a_rsp_data, a_rsp_id, a_req_ready, e.data, e.id);
            end
        end
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_rsp_valid !== 1'b1 || a_req_ready !== 4'b0) begin
            errors++;
            $display("FAIL bp_release: vld=%b ready=%b expected 1 0000", a_rsp_valid, a_req_ready);
        end
        @(negedge clk);
        checks++;
        if (a_rsp_valid !== 1'b0 || a_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_next: vld=%b ready=%b expected 0 0010", a_rsp_valid, a_req_ready);
        end
        model_ptr = 2;
        @(posedge clk);
        #1;
        a_req_valid = 4'b0;
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
            ok = a_rsp_valid;
        end
        e = sb.pop_front();
        checks++;
        if (!ok || a_rsp_data !== e.data || a_rsp_id !== e.id) begin
            errors++;
            $display("FAIL bp_second: seen=%0d data=%h id=%0d expected %h %0d", ok, a_rsp_data, a_rsp_id, e.data, e.id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_issue();
        int           cyc;
        bit           ok;
        bit           seen;
        logic [127:0] v1, v2;
        a_rsp_ready = 1'b1;
        a_src1[95:64] = 32'h12345678;
        a_src2[95:64] = 32'h00000100;
        a_req_valid = 4'b0100;
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
            ok = (a_req_ready != 4'b0);
        end
        checks++;
        if (a_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rst_grant: req_ready=%b expected 0100", a_req_ready);
        end
        @(posedge clk);
        #1;
        a_req_valid = 4'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_mc_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_issue: busy=%b mc_en=%b expected 1 1", a_busy, a_mc_en);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({a_req_ready, a_rsp_valid, a_rsp_id, a_rsp_data, a_busy, a_mc_en, a_mc_src1, a_mc_src2} !== '0) begin
            errors++;
            $display("FAIL rst_async: ready=%b vld=%b id=%0d data=%h busy=%b en=%b s1=%h s2=%h expected all 0",
                     a_req_ready, a_rsp_valid, a_rsp_id, a_rsp_data, a_busy, a_mc_en, a_mc_src1, a_mc_src2);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (a_rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_rsp: rsp_valid seen=%0d expected 0", seen);
        end
        @(posedge clk);
        #1;
        model_ptr = 0;
        v1 = '0; v2 = '0;
        v1[31:0]   = 32'h00000005; v2[31:0]   = 32'h00000006;
        v1[127:96] = 32'h00000011; v2[127:96] = 32'h00000002;
        run_op(4'b1001, v1, v2, 0, 32'd30, "rst_rr0");
        run_op(4'b1000, v1, v2, 3, 32'd34, "rst_rr3");
    endtask

    task automatic test_round_robin();
        logic [127:0] v1, v2;
        logic [3:0]   mask;
        logic [31:0]  x, y, z;
        int           ge;
        for (int n = 0; n < 10; n++) begin
            mask = (n < 8) ? 4'hF : 4'hE;
            for (int i = 0; i < NUM_REQ; i++) begin
                v1[i*32 +: 32] = $urandom;
                v2[i*32 +: 32] = $urandom;
            end
            ge = model_grant(mask, model_ptr);
            x = v1[ge*32 +: 32];
            y = v2[ge*32 +: 32];
            z = x * y;
            run_op(mask, v1, v2, ge, z, $sformatf("rr%0d", n));
        end
    endtask

    task automatic test_latency3();
        int          cyc, en_cnt, first;
        bit          ok;
        logic [31:0] d;
        logic [1:0]  id;
        exp_t        e;
        d = '0; id = '0;
        b_rsp_ready = 1'b1;
        b_src1 = '0; b_src2 = '0;
        b_src1[31:0] = 32'h0000FFFF;
        b_src2[31:0] = 32'h0000FFFF;
        b_req_valid = 4'b0001;
        sb.push_back('{id: 2'd0, data: 32'hFFFE0001});
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            cyc++;
            ok = (b_req_ready != 4'b0);
        end
        checks++;
        if (b_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL lat3_grant: req_ready=%b expected 0001", b_req_ready);
        end
        @(posedge clk);
        #1;
        b_req_valid = 4'b0;
        en_cnt = 0;
        first  = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (b_mc_en) en_cnt++;
            if (b_rsp_valid && first == 0) begin
                first = c;
                d  = b_rsp_data;
                id = b_rsp_id;
            end
        end
        e = sb.pop_front();
        checks++;
        if (en_cnt != 3) begin
            errors++;
            $display("FAIL lat3_en: mc_en high %0d cycles expected 3", en_cnt);
        end
        checks++;
        if (first != 5) begin
            errors++;
            $display("FAIL lat3_latency: rsp_valid at T+%0d expected T+5", first);
        end
        checks++;
        if (d !== e.data || id !== e.id) begin
            errors++;
            $display("FAIL lat3_data: data=%h id=%0d expected %h %0d", d, id, e.data, e.id);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_in_issue();
        test_round_robin();
        test_latency3();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
